// File: rtl/p405s_mac_acc_pkg.sv
// Package: p405s_mac_acc_pkg
// Purpose: shared definitions for the MAC saturating accumulator slice.
//   - command opcodes carried on in_op
//   - FSM state encoding for the accumulator control
//   - saturation clamp constants for word and halfword lanes
package p405s_mac_acc_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ACC   = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        SAT  = 2'b10,
        RESP = 2'b11
    } state_t;

    localparam logic [31:0] SAT_POS32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG32 = 32'h8000_0000;
    localparam logic [15:0] SAT_POS16 = 16'h7FFF;
    localparam logic [15:0] SAT_NEG16 = 16'h8000;

endpackage

// File: rtl/p405s_mac_add32_ctap.sv
// Module: p405s_mac_add32_ctap
// Purpose: combinational 32-bit adder exposing the carry out of bit 15 and
//   bit 31. In half mode the bit-15 carry is not propagated into the upper
//   half, so the two 16-bit lanes add independently.
// Ports:
//   a, b   in  32  addends
//   half   in  1   1 = split into two independent 16-bit lanes
//   sum    out 32  raw sum (mod 2^32, or two lanes mod 2^16)
//   c15    out 1   carry out of bit 15
//   c31    out 1   carry out of bit 31 (of the upper lane in half mode)
module p405s_mac_add32_ctap (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        half,
    output logic [31:0] sum,
    output logic        c15,
    output logic        c31
);

    logic [16:0] loSum;
    logic [16:0] hiSum;

    // The adder is built from two 17-bit halves so both carry taps are
    // available directly; half mode simply gates the carry between them.
    assign loSum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    assign hiSum = {1'b0, a[31:16]} + {1'b0, b[31:16]} + {16'b0, (loSum[16] & ~half)};

    assign sum = {hiSum[15:0], loSum[15:0]};
    assign c15 = loSum[16];
    assign c31 = hiSum[16];

endmodule

// File: rtl/p405s_mac_acc_sat.sv
// Module: p405s_mac_acc_sat
// Purpose: saturating 32-bit accumulator at the end of the MAC adder path.
//   Accepts LOAD/ACC/READ/CLEAR commands on a valid/ready input, adds either
//   one signed word or two independent signed halfwords, clamps on signed
//   overflow, keeps sticky overflow flags and returns READ results on a
//   valid/ready output.
// Ports:
//   cb         in  1   clock, rising edge
//   rst_n      in  1   synchronous active-low reset
//   in_valid   in  1   command present
//   in_ready   out 1   command accepted when in_valid & in_ready (IDLE only)
//   in_op      in  2   00 LOAD, 01 ACC, 10 READ, 11 CLEAR
//   in_half    in  1   dual 16-bit mode for this ACC
//   in_data    in  32  LOAD value or ACC addend
//   out_valid  out 1   READ result available
//   out_ready  in  1   consumer accepts result
//   out_data   out 32  accumulator value captured at READ
//   out_ovf    out 2   sticky flags captured at READ ([0] word/low, [1] high)
//   busy       out 1   state != IDLE
module p405s_mac_acc_sat
    import p405s_mac_acc_pkg::*;
(
    input  logic        cb,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic        in_half,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_ovf,
    output logic        busy
);

    state_t      state;
    logic [31:0] acc;
    logic [1:0]  flags;
    logic [31:0] opnd;
    logic        halfQ;
    logic [31:0] sumQ;
    logic        c15Q;
    logic        c31Q;

    logic [31:0] sumD;
    logic        c15D;
    logic        c31D;

    logic        cin31;
    logic        cin15;
    logic        ovfHi;
    logic        ovfLo;
    logic [31:0] satVal;
    logic [1:0]  satOvf;

    // The accumulator does not change while an ACC is in flight, so the
    // adder can read it directly during the ADD stage.
    p405s_mac_add32_ctap u_add (
        .a    (acc),
        .b    (opnd),
        .half (halfQ),
        .sum  (sumD),
        .c15  (c15D),
        .c31  (c31D)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Signed overflow of a lane is the carry into its sign bit differing
    // from the carry out of it; the carry-in is recovered from the sum and
    // operand sign bits. On overflow both operands share a sign, so the
    // addend's sign chooses the clamp direction.
    always_comb begin
        cin31  = sumQ[31] ^ acc[31] ^ opnd[31];
        cin15  = sumQ[15] ^ acc[15] ^ opnd[15];
        ovfHi  = c31Q ^ cin31;
        ovfLo  = c15Q ^ cin15;
        satVal = sumQ;
        satOvf = 2'b00;
        if (halfQ) begin
            if (ovfHi) begin
                satVal[31:16] = opnd[31] ? SAT_NEG16 : SAT_POS16;
            end
            if (ovfLo) begin
                satVal[15:0] = opnd[15] ? SAT_NEG16 : SAT_POS16;
            end
            satOvf = {ovfHi, ovfLo};
        end else begin
            if (ovfHi) begin
                satVal = opnd[31] ? SAT_NEG32 : SAT_POS32;
            end
            satOvf = {1'b0, ovfHi};
        end
    end

    // Control FSM plus all architectural state. LOAD and CLEAR finish in
    // IDLE; ACC walks ADD -> SAT; READ parks in RESP until the consumer
    // takes the result, which also clears the sticky flags.
    always_ff @(posedge cb) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 32'h0;
            flags     <= 2'b00;
            opnd      <= 32'h0;
            halfQ     <= 1'b0;
            sumQ      <= 32'h0;
            c15Q      <= 1'b0;
            c31Q      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_ovf   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        case (in_op)
                            OP_LOAD: begin
                                acc   <= in_data;
                                flags <= 2'b00;
                            end
                            OP_ACC: begin
                                opnd  <= in_data;
                                halfQ <= in_half;
                                state <= ADD;
                            end
                            OP_READ: begin
                                out_valid <= 1'b1;
                                out_data  <= acc;
                                out_ovf   <= flags;
                                state     <= RESP;
                            end
                            default: begin
                                acc   <= 32'h0;
                                flags <= 2'b00;
                            end
                        endcase
                    end
                end
                ADD: begin
                    sumQ  <= sumD;
                    c15Q  <= c15D;
                    c31Q  <= c31D;
                    state <= SAT;
                end
                SAT: begin
                    acc   <= satVal;
                    flags <= flags | satOvf;
                    state <= IDLE;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        flags     <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p405s_mac_acc_sat.sv
// Testbench: tb_p405s_mac_acc_sat
// Purpose: directed scenarios followed by a randomized command stream, all
//   checked against a signed-arithmetic reference model of the accumulator.
module tb_p405s_mac_acc_sat;
    import p405s_mac_acc_pkg::*;

    logic        cb = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic        in_half = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_ovf;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] accM = 32'h0;
    logic [1:0]  flagsM = 2'b00;

    p405s_mac_acc_sat dut (
        .cb        (cb),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_half   (in_half),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 cb = ~cb;

    // Advance one clock and settle just past the rising edge; inputs are
    // driven and outputs sampled from here.
    task automatic stepCycle();
        @(posedge cb);
        #1;
    endtask

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference ACC: plain signed arithmetic with explicit range clamping.
    function automatic void modelAcc(input logic half, input logic [31:0] d);
        longint s;
        int     hi;
        int     lo;
        if (!half) begin
            s = longint'($signed(accM)) + longint'($signed(d));
            if (s > 64'sh7FFF_FFFF) begin
                s = 64'sh7FFF_FFFF;
                flagsM[0] = 1'b1;
            end else if (s < -64'sh8000_0000) begin
                s = -64'sh8000_0000;
                flagsM[0] = 1'b1;
            end
            accM = s[31:0];
        end else begin
            hi = int'($signed(accM[31:16])) + int'($signed(d[31:16]));
            lo = int'($signed(accM[15:0])) + int'($signed(d[15:0]));
            if (hi > 32767) begin
                hi = 32767;
                flagsM[1] = 1'b1;
            end else if (hi < -32768) begin
                hi = -32768;
                flagsM[1] = 1'b1;
            end
            if (lo > 32767) begin
                lo = 32767;
                flagsM[0] = 1'b1;
            end else if (lo < -32768) begin
                lo = -32768;
                flagsM[0] = 1'b1;
            end
            accM = {hi[15:0], lo[15:0]};
        end
    endfunction

    // Issue one command once the DUT is ready (bounded wait), return one
    // cycle after acceptance, and update the reference model.
    task automatic applyStimulus(input logic [1:0] op, input logic half, input logic [31:0] data);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            stepCycle();
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b1;
        in_op    = op;
        in_half  = half;
        in_data  = data;
        stepCycle();
        in_valid = 1'b0;
        case (op)
            OP_LOAD: begin
                accM   = data;
                flagsM = 2'b00;
            end
            OP_CLEAR: begin
                accM   = 32'h0;
                flagsM = 2'b00;
            end
            OP_ACC: modelAcc(half, data);
            default: ;
        endcase
    endtask

    // READ with out_ready held high: result appears one cycle after
    // acceptance and is consumed on the following edge.
    task automatic readCheck(input string tag);
        applyStimulus(OP_READ, 1'b0, 32'h0);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_data"}, out_data, accM);
        checkOutput({tag, "_ovf"}, {30'b0, out_ovf}, {30'b0, flagsM});
        stepCycle();
        flagsM = 2'b00;
        checkOutput({tag, "_done"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] heldData;
        logic [1:0]  heldOvf;
        logic [31:0] d;
        int          r;

        // Power-on reset
        stepCycle();
        stepCycle();
        checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_data", out_data, 32'h0);
        checkOutput("rst_ovf", {30'b0, out_ovf}, 32'd0);
        rst_n = 1'b1;

        // Reset while an ACC is in the ADD stage discards it
        applyStimulus(OP_LOAD, 1'b0, 32'h0000_0011);
        applyStimulus(OP_ACC, 1'b0, 32'h0000_0022);
        checkOutput("midacc_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        accM = 32'h0;
        flagsM = 2'b00;
        checkOutput("midacc_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midacc_valid", {31'b0, out_valid}, 32'd0);
        readCheck("after_rst");

        // Word add and ACC latency as seen on in_ready
        applyStimulus(OP_LOAD, 1'b0, 32'h0000_0005);
        applyStimulus(OP_ACC, 1'b0, 32'hFFFF_FFFD);
        checkOutput("acc_ready_n1", {31'b0, in_ready}, 32'd0);
        stepCycle();
        checkOutput("acc_ready_n2", {31'b0, in_ready}, 32'd0);
        stepCycle();
        checkOutput("acc_ready_n3", {31'b0, in_ready}, 32'd1);
        readCheck("word_add");

        // Word saturation both directions
        applyStimulus(OP_LOAD, 1'b0, 32'h7FFF_FFF0);
        applyStimulus(OP_ACC, 1'b0, 32'h0000_0100);
        readCheck("sat_pos");
        applyStimulus(OP_LOAD, 1'b0, 32'h8000_0001);
        applyStimulus(OP_ACC, 1'b0, 32'hFFFF_FFF0);
        readCheck("sat_neg");

        // Half mode: upper lane clamps, lower lane wraps to zero without carry
        applyStimulus(OP_LOAD, 1'b0, 32'h7FF0_FFFF);
        applyStimulus(OP_ACC, 1'b1, 32'h0020_0001);
        readCheck("half");

        // Output backpressure: result held, commands refused
        applyStimulus(OP_LOAD, 1'b0, 32'h7FFF_FFF0);
        applyStimulus(OP_ACC, 1'b0, 32'h0000_0100);
        out_ready = 1'b0;
        applyStimulus(OP_READ, 1'b0, 32'h0);
        heldData = accM;
        heldOvf = flagsM;
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_data", out_data, heldData);
            checkOutput("bp_ovf", {30'b0, out_ovf}, {30'b0, heldOvf});
            checkOutput("bp_ready", {31'b0, in_ready}, 32'd0);
            in_valid = (k % 2 == 0);
            in_op = OP_CLEAR;
            stepCycle();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        stepCycle();
        flagsM = 2'b00;
        checkOutput("bp_release", {31'b0, out_valid}, 32'd0);
        checkOutput("bp_hold_data", out_data, heldData);
        readCheck("bp_second");

        // Sticky flags survive a later clean ACC; CLEAR drops everything
        applyStimulus(OP_LOAD, 1'b0, 32'h7FFF_FFF0);
        applyStimulus(OP_ACC, 1'b0, 32'h0000_0100);
        applyStimulus(OP_ACC, 1'b0, 32'hFFFF_FFFF);
        readCheck("sticky");
        applyStimulus(OP_CLEAR, 1'b0, 32'hDEAD_BEEF);
        readCheck("clear");

        // Randomized command stream, biased toward the saturation boundaries
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'h7FF0_7FF0 + ($urandom & 32'h001F_001F);
                2: d = 32'h8000_8000 + ($urandom & 32'h001F_001F);
                default: d = $urandom & 32'h0000_00FF;
            endcase
            r = $urandom_range(0, 9);
            if (r < 2) begin
                applyStimulus(OP_LOAD, 1'b0, d);
            end else if (r < 7) begin
                applyStimulus(OP_ACC, 1'($urandom_range(0, 1)), d);
            end else if (r < 9) begin
                readCheck("rand_read");
            end else begin
                applyStimulus(OP_CLEAR, 1'b0, d);
            end
        end
        readCheck("rand_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
